// File: rtl/de1_button_reset.sv
`default_nettype none
// ============================================================================
// Module   : de1_button_reset
// Purpose  : Synchronise and debounce the four DE1 push buttons, emit press /
//            release strobes and a stretched system reset driven by button 0.
// Revision : 1.0  initial release
// ============================================================================
module de1_button_reset #(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 5,
    parameter int PULSE_CLK   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic [3:0] btn_q,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       sys_reset,
    output logic       ms_tick
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(DEBOUNCE_MS + 1);
    localparam int SW  = $clog2(PULSE_CLK + 1);

    localparam logic [PW-1:0] DIV_LAST     = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_MS - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(PULSE_CLK);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        STRETCH = 2'd2
    } state_t;

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    raw_p;
    logic [PW-1:0] presc;
    logic [3:0]    q_d;
    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_nxt;

    // Released buttons read high, so the synchroniser idles at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign raw_p = ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            ms_tick <= 1'b0;
        end else if (presc == DIV_LAST) begin
            presc   <= '0;
            ms_tick <= 1'b1;
        end else begin
            presc   <= presc + PW'(1);
            ms_tick <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_debounce
            logic [DW-1:0] cnt;
            logic          q;

            // Count only consecutive disagreeing ticks; any agreement restarts.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    q   <= 1'b0;
                end else if (ms_tick) begin
                    if (raw_p[i] == q) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        cnt <= '0;
                        q   <= raw_p[i];
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
            end

            assign btn_q[i] = q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_d         <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            q_d         <= btn_q;
            btn_press   <= btn_q & ~q_d;
            btn_release <= ~btn_q & q_d;
        end
    end

    // Reset stretcher: sys_reset is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STRETCH;
            scnt      <= STRETCH_LOAD;
            sys_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            scnt      <= scnt_nxt;
            sys_reset <= (state_nxt != RUN);
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        case (state)
            RUN: begin
                if (btn_q[0]) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!btn_q[0]) begin
                    state_nxt = STRETCH;
                    scnt_nxt  = STRETCH_LOAD;
                end
            end
            STRETCH: begin
                if (btn_q[0]) begin
                    state_nxt = HOLD;
                end else if (scnt <= SW'(1)) begin
                    state_nxt = RUN;
                end else begin
                    scnt_nxt = scnt - SW'(1);
                end
            end
            default: begin
                state_nxt = STRETCH;
                scnt_nxt  = STRETCH_LOAD;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_de1_button_reset.sv
`default_nettype none
// ============================================================================
// Module   : tb_de1_button_reset
// Purpose  : Directed self-checking bench with a window-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_de1_button_reset;

    localparam int CLK_HZ      = 10000;
    localparam int DEBOUNCE_MS = 5;
    localparam int PULSE_CLK   = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic [3:0] btn_q;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       sys_reset;
    logic       ms_tick;

    int n_checks = 0;
    int n_fail   = 0;
    logic started = 1'b0;

    de1_button_reset #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .PULSE_CLK   (PULSE_CLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_q       (btn_q),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .sys_reset   (sys_reset),
        .ms_tick     (ms_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: btn_q flips when the last DEBOUNCE_MS tick samples all
    // disagree with it; sys_reset is high for PULSE_CLK clocks after rst, and
    // while button 0 was seen pressed within the last PULSE_CLK+1 samples.
    int         m_cyc;
    logic [3:0] m_s1, m_s2, m_q, m_qn, m_qd, m_press, m_rel;
    logic       m_tick, m_sysr;
    logic [PULSE_CLK:0] m_q0h;
    logic [DEBOUNCE_MS-1:0] m_win [4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_s1 = '1; m_s2 = '1; m_q = '0; m_qd = '0;
            m_press = '0; m_rel = '0; m_tick = 1'b0; m_sysr = 1'b1; m_q0h = '0;
            for (int b = 0; b < 4; b++) m_win[b] = '0;
        end else begin
            m_qn = m_q;
            if (m_tick) begin
                for (int b = 0; b < 4; b++) begin
                    m_win[b] = {m_win[b][DEBOUNCE_MS-2:0], ~m_s2[b]};
                    if (m_win[b] == {DEBOUNCE_MS{~m_q[b]}}) m_qn[b] = ~m_q[b];
                end
            end
            m_press = m_q & ~m_qd;
            m_rel   = ~m_q & m_qd;
            m_qd    = m_q;
            m_q0h   = {m_q0h[PULSE_CLK-1:0], m_q[0]};
            m_q     = m_qn;
            m_cyc++;
            m_tick  = (m_cyc % (CLK_HZ / 1000) == 0);
            m_sysr  = (m_cyc < PULSE_CLK) || (m_q0h != '0);
            m_s2    = m_s1;
            m_s1    = btn_n;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_btn_q", btn_q, m_q);
            check("model_btn_press", btn_press, m_press);
            check("model_btn_release", btn_release, m_rel);
            check("model_sys_reset", sys_reset, m_sysr);
            check("model_ms_tick", ms_tick, m_tick);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    int   rise_k, fall_k, tick_k, bad, cnt_a, cnt_b;
    logic prev, sr_at, sr_next;

    initial begin
        rst   = 1'b1;
        btn_n = 4'hF;
        #1 started = 1'b1;

        // Power-up
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        fall_k = 0; tick_k = 0; bad = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (!sys_reset && fall_k == 0) fall_k = k;
            if (ms_tick && tick_k == 0) tick_k = k;
            if (btn_q != 0 || btn_press != 0 || btn_release != 0) bad++;
        end
        check("por_sys_reset_clks", fall_k, 7);
        check("por_first_ms_tick", tick_k, 10);
        check("por_buttons_quiet", bad, 0);

        // Button 1 held
        btn_n[1] = 1'b0; rise_k = 0; cnt_a = 0; bad = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (btn_q[1] && rise_k == 0) rise_k = k;
            if (btn_press[1]) cnt_a++;
            if (sys_reset) bad++;
        end
        check("btn1_rise_in_42_52", (rise_k >= 42 && rise_k <= 52) ? 1 : 0, 1);
        check("btn1_press_count", cnt_a, 1);
        check("btn1_sys_reset_quiet", bad, 0);

        // Glitch on button 2
        btn_n[2] = 1'b0; cnt_a = 0; bad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 31) btn_n[2] = 1'b1;
            @(posedge clk); #1;
            if (btn_q[2]) bad++;
            if (btn_press[2] || btn_release[2]) cnt_a++;
        end
        check("glitch_btn_q2", bad, 0);
        check("glitch_strobes", cnt_a, 0);

        // Bouncing press on button 3
        btn_n[3] = 1'b0; cnt_a = 0; cnt_b = 0; prev = btn_q[3];
        for (int k = 1; k <= 110; k++) begin
            if (k < 40 && k % 7 == 0) btn_n[3] = ~btn_n[3];
            if (k == 40) btn_n[3] = 1'b0;
            @(posedge clk); #1;
            if (btn_press[3]) cnt_a++;
            if (btn_q[3] && !prev) cnt_b++;
            prev = btn_q[3];
        end
        check("bounce_press_count", cnt_a, 1);
        check("bounce_rise_count", cnt_b, 1);

        // Bouncing release on button 3
        btn_n[3] = 1'b1; cnt_a = 0; cnt_b = 0; prev = btn_q[3];
        for (int k = 1; k <= 110; k++) begin
            if (k < 40 && k % 7 == 0) btn_n[3] = ~btn_n[3];
            if (k == 40) btn_n[3] = 1'b1;
            @(posedge clk); #1;
            if (btn_release[3]) cnt_a++;
            if (!btn_q[3] && prev) cnt_b++;
            prev = btn_q[3];
        end
        check("bounce_release_count", cnt_a, 1);
        check("bounce_fall_count", cnt_b, 1);

        // Button 0 press: sys_reset rises one clock after btn_q[0]
        btn_n[0] = 1'b0; rise_k = 0; sr_at = 1'b1; sr_next = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (btn_q[0] && rise_k == 0) begin
                rise_k = k;
                sr_at  = sys_reset;
            end else if (rise_k != 0 && rise_k == k - 1) begin
                sr_next = sys_reset;
            end
        end
        check("btn0_sys_reset_at_rise", sr_at, 0);
        check("btn0_sys_reset_after_rise", sr_next, 1);

        // Release: sys_reset holds PULSE_CLK clocks past the clock after the fall
        btn_n[0] = 1'b1; fall_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (!btn_q[0]) begin fall_k = k; break; end
        end
        check("btn0_fall_in_42_52", (fall_k >= 42 && fall_k <= 52) ? 1 : 0, 1);
        cnt_a = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (!sys_reset) begin cnt_a = k; break; end
        end
        check("btn0_stretch_clks", cnt_a, 8);

        // Second press, then reset pulse mid-stretch with button 1 still held
        btn_n[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1 btn_n[0] = 1'b1; fall_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (!btn_q[0]) begin fall_k = k; break; end
        end
        check("btn0_second_fall_seen", (fall_k != 0) ? 1 : 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_stretching", sys_reset, 1);
        check("pre_rst_btn1_held", btn_q[1], 1);
        rst = 1'b1;
        #1;
        check("async_rst_btn_q", btn_q, 0);
        check("async_rst_strobes", {btn_press, btn_release}, 0);
        check("async_rst_ms_tick", ms_tick, 0);
        check("async_rst_sys_reset", sys_reset, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rise_k = 0; fall_k = 0;
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            if (btn_q[1] && rise_k == 0) rise_k = k;
            if (!sys_reset && fall_k == 0) fall_k = k;
        end
        check("post_rst_sys_reset_clks", fall_k, 7);
        check("post_rst_btn1_requalify", (rise_k >= 42 && rise_k <= 52) ? 1 : 0, 1);

        started = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
